// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit feeding decode.
// Latches PC into a memory request, captures the response into the IR.
module instr_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_FULL
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                pc_advance_q;
  logic                ir_valid_q;
  logic [DATA_W-1:0]   ir_data_q;
  logic [ADDR_W-1:0]   ir_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      pc_advance_q <= 1'b0;
      ir_valid_q   <= 1'b0;
      ir_data_q    <= NOP_WORD;
      ir_pc_q      <= '0;
    end else begin
      pc_advance_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_en) begin
            state_q    <= S_REQ;
            mem_addr_q <= pc;
          end
        end
        S_REQ: begin
          // a granted request stays outstanding even when flushed
          if (mem_gnt) begin
            state_q <= flush ? S_DROP : S_WAIT;
          end else if (flush) begin
            mem_addr_q <= pc;
          end
        end
        S_WAIT: begin
          if (mem_rvalid && !flush) begin
            state_q      <= S_FULL;
            ir_data_q    <= mem_rdata;
            ir_pc_q      <= mem_addr_q;
            ir_valid_q   <= 1'b1;
            pc_advance_q <= 1'b1;
          end else if (mem_rvalid) begin
            state_q <= fetch_en ? S_REQ : S_IDLE;
            if (fetch_en) mem_addr_q <= pc;
          end else if (flush) begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (mem_rvalid) begin
            state_q <= fetch_en ? S_REQ : S_IDLE;
            if (fetch_en) mem_addr_q <= pc;
          end
        end
        S_FULL: begin
          if (flush || ir_ready) begin
            ir_valid_q <= 1'b0;
            if (flush) ir_data_q <= NOP_WORD;
            state_q <= fetch_en ? S_REQ : S_IDLE;
            if (fetch_en) mem_addr_q <= pc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = mem_addr_q;
  assign pc_advance = pc_advance_q;
  assign ir_valid   = ir_valid_q;
  assign ir_data    = ir_data_q;
  assign ir_pc      = ir_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenario tests for the instruction fetch unit.
// Each task drives one scenario and checks its own hand-computed values.
module tb_instr_fetch;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_en = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          ir_ready = 1'b0;
  logic          pc_advance;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          ir_valid;
  logic [DW-1:0] ir_data;
  logic [AW-1:0] ir_pc;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .flush     (flush),
    .pc        (pc),
    .pc_advance(pc_advance),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .ir_valid  (ir_valid),
    .ir_data   (ir_data),
    .ir_pc     (ir_pc),
    .ir_ready  (ir_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    step();
    step();
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    n_vec++; if (pc_advance !== 1'b0) begin n_err++; $display("FAIL rst_adv: got %b want 0", pc_advance); end
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_irv: got %b want 0", ir_valid); end
    n_vec++; if (ir_data !== 32'h0) begin n_err++; $display("FAIL rst_ird: got %h want 0", ir_data); end
    n_vec++; if (ir_pc !== 32'h0) begin n_err++; $display("FAIL rst_irpc: got %h want 0", ir_pc); end
    rst = 1'b1;
    step();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_rvalid = 1'b0;
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL idle_rv_irv: got %b want 0", ir_valid); end
    n_vec++; if (ir_data !== 32'h0) begin n_err++; $display("FAIL idle_rv_ird: got %h want 0", ir_data); end
  endtask

  task automatic test_single();
    bit ok;
    int pulses;
    pc = 32'h800;
    fetch_en = 1'b1;
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_req: got timeout want mem_req"); end
    n_vec++; if (mem_addr !== 32'h800) begin n_err++; $display("FAIL single_addr: got %h want 800", mem_addr); end
    mem_gnt = 1'b1;
    fetch_en = 1'b0;
    step();
    mem_gnt = 1'b0;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL single_wait_req: got %b want 0", mem_req); end
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL single_irv: got %b want 1", ir_valid); end
    n_vec++; if (ir_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_ird: got %h want deadbeef", ir_data); end
    n_vec++; if (ir_pc !== 32'h800) begin n_err++; $display("FAIL single_irpc: got %h want 800", ir_pc); end
    n_vec++; if (pc_advance !== 1'b1) begin n_err++; $display("FAIL single_adv: got %b want 1", pc_advance); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(pc_advance);
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL single_pulse: got %0d extra want 0", pulses); end
    n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL single_hold: got %b want 1", ir_valid); end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL single_cons: got %b want 0", ir_valid); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", mem_req); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [AW-1:0] exp_pc;
    logic [DW-1:0] exp_d;
    pc = 32'h800;
    ir_ready = 1'b1;
    fetch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h800 + AW'(i);
      exp_d = 32'hA000_0000 + DW'(i);
      wait_req(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_req%0d: got timeout want mem_req", i); end
      n_vec++; if (mem_addr !== exp_pc) begin n_err++; $display("FAIL b2b_addr%0d: got %h want %h", i, mem_addr, exp_pc); end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = exp_d;
      step();
      mem_rvalid = 1'b0;
      n_vec++; if (ir_pc !== exp_pc) begin n_err++; $display("FAIL b2b_irpc%0d: got %h want %h", i, ir_pc, exp_pc); end
      n_vec++; if (ir_data !== exp_d) begin n_err++; $display("FAIL b2b_ird%0d: got %h want %h", i, ir_data, exp_d); end
      n_vec++; if (pc_advance !== 1'b1) begin n_err++; $display("FAIL b2b_adv%0d: got %b want 1", i, pc_advance); end
      if (pc_advance) pc = pc + 1;
      if (i == 2) fetch_en = 1'b0;
    end
    step();
    ir_ready = 1'b0;
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_irv: got %b want 0", ir_valid); end
  endtask

  task automatic test_gnt_stall();
    bit ok;
    pc = 32'h800;
    fetch_en = 1'b1;
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_req: got timeout want mem_req"); end
    fetch_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pc = 32'h900 + AW'(k * 4);
      step();
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stall_req%0d: got %b want 1", k, mem_req); end
      n_vec++; if (mem_addr !== 32'h800) begin n_err++; $display("FAIL stall_addr%0d: got %h want 800", k, mem_addr); end
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    n_vec++; if (ir_pc !== 32'h800) begin n_err++; $display("FAIL stall_irpc: got %h want 800", ir_pc); end
    n_vec++; if (ir_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL stall_ird: got %h want cafef00d", ir_data); end
    n_vec++; if (pc_advance !== 1'b1) begin n_err++; $display("FAIL stall_adv: got %b want 1", pc_advance); end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b want 0", mem_req); end
  endtask

  task automatic test_flush_wait();
    bit ok;
    pc = 32'h800;
    fetch_en = 1'b1;
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL fw_req: got timeout want mem_req"); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    flush = 1'b1;
    pc = 32'h1000;
    step();
    flush = 1'b0;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fw_drop_req: got %b want 0", mem_req); end
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1111_1111;
    step();
    mem_rvalid = 1'b0;
    n_vec++; if (pc_advance !== 1'b0) begin n_err++; $display("FAIL fw_adv: got %b want 0", pc_advance); end
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fw_irv: got %b want 0", ir_valid); end
    n_vec++; if (ir_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL fw_ird: got %h want cafef00d", ir_data); end
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fw_rereq: got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h1000) begin n_err++; $display("FAIL fw_addr: got %h want 1000", mem_addr); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h2222_2222;
    step();
    mem_rvalid = 1'b0;
    n_vec++; if (ir_data !== 32'h2222_2222) begin n_err++; $display("FAIL fw_new_ird: got %h want 22222222", ir_data); end
    n_vec++; if (ir_pc !== 32'h1000) begin n_err++; $display("FAIL fw_new_irpc: got %h want 1000", ir_pc); end
    ir_ready = 1'b1;
    fetch_en = 1'b0;
    step();
    ir_ready = 1'b0;
  endtask

  task automatic test_flush_gnt_rvalid();
    bit ok;
    pc = 32'h2000;
    fetch_en = 1'b1;
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL fg_req: got timeout want mem_req"); end
    mem_gnt = 1'b1;
    flush = 1'b1;
    pc = 32'h3000;
    step();
    mem_gnt = 1'b0;
    flush = 1'b0;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fg_drop_req: got %b want 0", mem_req); end
    mem_rvalid = 1'b1;
    flush = 1'b1;
    mem_rdata = 32'h3333_3333;
    step();
    mem_rvalid = 1'b0;
    flush = 1'b0;
    n_vec++; if (pc_advance !== 1'b0) begin n_err++; $display("FAIL fg_adv: got %b want 0", pc_advance); end
    n_vec++; if (ir_data !== 32'h2222_2222) begin n_err++; $display("FAIL fg_ird: got %h want 22222222", ir_data); end
    n_vec++; if (mem_addr !== 32'h3000) begin n_err++; $display("FAIL fg_addr: got %h want 3000", mem_addr); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    flush = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h3A3A_3A3A;
    pc = 32'h4000;
    step();
    flush = 1'b0;
    mem_rvalid = 1'b0;
    n_vec++; if (pc_advance !== 1'b0) begin n_err++; $display("FAIL fr_adv: got %b want 0", pc_advance); end
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fr_irv: got %b want 0", ir_valid); end
    n_vec++; if (ir_data !== 32'h2222_2222) begin n_err++; $display("FAIL fr_ird: got %h want 22222222", ir_data); end
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fr_req: got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h4000) begin n_err++; $display("FAIL fr_addr: got %h want 4000", mem_addr); end
    fetch_en = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h4444_4444;
    step();
    mem_rvalid = 1'b0;
    n_vec++; if (ir_data !== 32'h4444_4444) begin n_err++; $display("FAIL fr_new_ird: got %h want 44444444", ir_data); end
    n_vec++; if (ir_pc !== 32'h4000) begin n_err++; $display("FAIL fr_new_irpc: got %h want 4000", ir_pc); end
  endtask

  task automatic test_stall_flush_reset();
    bit ok;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBADB_AD00 + DW'(i);
      step();
      n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL full_irv%0d: got %b want 1", i, ir_valid); end
      n_vec++; if (ir_data !== 32'h4444_4444) begin n_err++; $display("FAIL full_ird%0d: got %h want 44444444", i, ir_data); end
    end
    mem_rvalid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL ff_irv: got %b want 0", ir_valid); end
    n_vec++; if (ir_data !== 32'h0) begin n_err++; $display("FAIL ff_ird: got %h want 0", ir_data); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ff_idle: got %b want 0", mem_req); end
    pc = 32'h5000;
    fetch_en = 1'b1;
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ar_req: got timeout want mem_req"); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    n_vec++; if (mem_addr !== 32'h5000) begin n_err++; $display("FAIL ar_pre_addr: got %h want 5000", mem_addr); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ar_req0: got %b want 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL ar_addr: got %h want 0", mem_addr); end
    n_vec++; if (pc_advance !== 1'b0) begin n_err++; $display("FAIL ar_adv: got %b want 0", pc_advance); end
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL ar_irv: got %b want 0", ir_valid); end
    n_vec++; if (ir_data !== 32'h0) begin n_err++; $display("FAIL ar_ird: got %h want 0", ir_data); end
    n_vec++; if (ir_pc !== 32'h0) begin n_err++; $display("FAIL ar_irpc: got %h want 0", ir_pc); end
    fetch_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ar_post_idle: got %b want 0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gnt_stall();
    test_flush_wait();
    test_flush_gnt_rvalid();
    test_stall_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
